// File: rtl/piled_split_sched.sv
// Splits a piled word {D,C,B,A} into up to four per-channel element streams,
// one frame of ARR_LEN words at a time, with per-channel backpressure.
module piled_split_sched #(
  parameter int ELEM_W  = 8,
  parameter int ARR_LEN = 32,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          cfg_num_arr,
  input  logic [4*ELEM_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*ELEM_W-1:0] out_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [3:0]          out_last,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload holds while valid && !ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       n_act;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       act_mask;
  logic [3:0]       out_fire;
  logic             in_fire;
  logic             last_elem;

  always_comb begin
    act_mask = '0;
    for (int i = 0; i < 4; i++) begin
      act_mask[i] = (2'(i) <= n_act);
    end
  end

  assign out_fire  = out_valid & out_ready & act_mask;
  assign in_fire   = in_valid & in_ready;
  assign last_elem = (cnt == CNT_W'(ARR_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (abort)                      state_nxt = IDLE;
        else if (in_fire && last_elem)  state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort)                   state_nxt = IDLE;
        else if (out_valid == 4'b0)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new word is taken only when every active lane can accept its element.
  always_comb begin
    in_ready = (state == RUN);
    for (int i = 0; i < 4; i++) begin
      if (act_mask[i] && out_valid[i] && !out_ready[i]) in_ready = 1'b0;
    end
    busy      = (state != IDLE);
    done      = (state == DRAIN) && (out_valid == 4'b0) && !abort;
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      n_act     <= '0;
      out_valid <= '0;
      out_last  <= '0;
      out_data  <= '0;
    end else if (abort && state != IDLE) begin
      cnt       <= '0;
      out_valid <= '0;
      out_last  <= '0;
    end else begin
      if (state == IDLE && start) begin
        n_act <= cfg_num_arr;
        cnt   <= '0;
      end else if (in_fire) begin
        cnt <= cnt + CNT_W'(1);
      end
      // Last is cleared on an unreplaced fire so idle lanes never show a stale last.
      for (int i = 0; i < 4; i++) begin
        if (in_fire && act_mask[i]) begin
          out_data[i*ELEM_W +: ELEM_W] <= in_data[i*ELEM_W +: ELEM_W];
          out_valid[i]                 <= 1'b1;
          out_last[i]                  <= last_elem;
        end else if (out_fire[i]) begin
          out_valid[i] <= 1'b0;
          out_last[i]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_piled_split_sched.sv
// Bench for piled_split_sched: directed scenarios plus randomized frames, all
// checked every cycle against a per-lane queue model of the frame.
`timescale 1ns/1ps
module tb_piled_split_sched;
  localparam int EW      = 8;
  localparam int ARR_LEN = 4;
  localparam int DW      = 4 * EW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [1:0]    cfg_num_arr;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [3:0]    out_last;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  piled_split_sched #(.ELEM_W(EW), .ARR_LEN(ARR_LEN), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_num_arr(cfg_num_arr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Model: per lane, elements accepted but not yet consumed, tagged with last.
  logic [EW:0]   mq[4][$];
  logic [EW-1:0] last_lane[4];
  logic          m_active;
  int            m_acc;
  logic [1:0]    m_nact;
  int            rx_cnt[4];
  int            last_cnt[4];
  int            done_cnt;
  logic [EW-1:0] rx_log[4][$];
  bit            mon_en   = 1'b0;
  bit            rand_rdy = 1'b0;
  int            n_checks = 0;
  int            n_fail   = 0;

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 4'($urandom);
  end

  always @(negedge clk) begin : monitor
    logic [3:0]    act;
    logic [3:0]    e_valid;
    logic [3:0]    e_last;
    logic [DW-1:0] e_data;
    logic          e_ready;
    logic          e_done;
    logic          all_empty;
    logic          was_active;
    logic [EW:0]   ent;
    if (mon_en) begin
      was_active = m_active;
      all_empty  = 1'b1;
      e_ready    = m_active && (m_acc < ARR_LEN);
      for (int i = 0; i < 4; i++) begin
        act[i]     = (i <= int'(m_nact));
        e_valid[i] = (mq[i].size() != 0);
        e_last[i]  = e_valid[i] ? mq[i][0][EW] : 1'b0;
        e_data[i*EW +: EW] = last_lane[i];
        if (e_valid[i]) all_empty = 1'b0;
        if (e_valid[i] && !out_ready[i]) e_ready = 1'b0;
      end
      e_done = m_active && (m_acc == ARR_LEN) && all_empty && !abort;

      n_checks += 6;
      if (out_valid !== e_valid) begin
        n_fail++; $display("FAIL mon_out_valid @%0t: got %b expected %b", $time, out_valid, e_valid);
      end
      if (out_data !== e_data) begin
        n_fail++; $display("FAIL mon_out_data @%0t: got %h expected %h", $time, out_data, e_data);
      end
      if (out_last !== e_last) begin
        n_fail++; $display("FAIL mon_out_last @%0t: got %b expected %b", $time, out_last, e_last);
      end
      if (in_ready !== e_ready) begin
        n_fail++; $display("FAIL mon_in_ready @%0t: got %b expected %b", $time, in_ready, e_ready);
      end
      if (busy !== m_active) begin
        n_fail++; $display("FAIL mon_busy @%0t: got %b expected %b", $time, busy, m_active);
      end
      if (done !== e_done) begin
        n_fail++; $display("FAIL mon_done @%0t: got %b expected %b", $time, done, e_done);
      end

      if (abort && m_active) begin
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_active = 1'b0;
        m_acc    = 0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (mq[i].size() != 0 && out_ready[i]) begin
            ent = mq[i].pop_front();
            rx_cnt[i]++;
            rx_log[i].push_back(ent[EW-1:0]);
            if (ent[EW]) last_cnt[i]++;
          end
        end
        if (in_valid && e_ready) begin
          for (int i = 0; i < 4; i++) begin
            if (act[i]) begin
              mq[i].push_back({(m_acc == ARR_LEN - 1), in_data[i*EW +: EW]});
              last_lane[i] = in_data[i*EW +: EW];
            end
          end
          m_acc++;
        end
        if (e_done) begin
          m_active = 1'b0;
          done_cnt++;
        end else if (!was_active && start) begin
          m_active = 1'b1;
          m_acc    = 0;
          m_nact   = cfg_num_arr;
        end
      end
    end
  end

  function automatic logic [DW-1:0] word_of(input int k);
    return {EW'(0), EW'(3*k + 3), EW'(3*k + 2), EW'(3*k + 1)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      last_lane[i] = '0;
    end
    m_active = 1'b0;
    m_acc    = 0;
    m_nact   = '0;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      rx_cnt[i]   = 0;
      last_cnt[i] = 0;
      rx_log[i].delete();
    end
    done_cnt = 0;
  endtask

  task automatic start_frame(input logic [1:0] n);
    @(posedge clk); #1;
    start = 1'b1; cfg_num_arr = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream(input int nwords, input int base, input int vpct,
                        input bit fixed, output int cycles);
    int sent;
    bit fired;
    sent = 0; cycles = 0;
    while (sent < nwords && cycles < 500) begin
      if (!in_valid && $urandom_range(99) < vpct) begin
        in_valid = 1'b1;
        in_data  = fixed ? word_of(base + sent) : DW'($urandom);
      end
      @(negedge clk);
      fired = in_valid && in_ready;
      @(posedge clk); #1;
      cycles++;
      if (fired) begin sent++; in_valid = 1'b0; end
    end
    n_checks++;
    if (sent != nwords) begin
      n_fail++; $display("FAIL stream_words: sent %0d expected %0d", sent, nwords);
    end
  endtask

  task automatic wait_idle(input int limit);
    int guard;
    guard = 0;
    while (m_active && guard < limit) begin
      @(posedge clk);
      guard++;
    end
    n_checks++;
    if (m_active) begin
      n_fail++; $display("FAIL frame_done_timeout: still active after %0d cycles, expected idle", guard);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input string name, input int a, input int b, input int c, input int d, input int dn);
    int exp_rx[4];
    exp_rx = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx_cnt[i] != exp_rx[i]) begin
        n_fail++; $display("FAIL %s_rx_cnt[%0d]: got %0d expected %0d", name, i, rx_cnt[i], exp_rx[i]);
      end
    end
    n_checks++;
    if (done_cnt != dn) begin
      n_fail++; $display("FAIL %s_done_cnt: got %0d expected %0d", name, done_cnt, dn);
    end
  endtask

  task automatic test_reset();
    start = 1'b0; abort = 1'b0; cfg_num_arr = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 4'hF; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks += 7;
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    if (out_valid !== 4'h0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
    if (out_last !== 4'h0)  begin n_fail++; $display("FAIL reset_out_last: got %b expected 0000", out_last); end
    if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_clear(); clear_stats();
    mon_en = 1'b1;
    // Data offered with no start must be refused.
    in_valid = 1'b1; in_data = word_of(0);
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    clear_stats();
    start_frame(2'd2);
    stream(ARR_LEN, 0, 100, 1'b1, cyc);
    wait_idle(50);
    n_checks++;
    if (cyc != ARR_LEN) begin
      n_fail++; $display("FAIL basic_throughput: got %0d cycles expected %0d", cyc, ARR_LEN);
    end
    check_counts("basic", 4, 4, 4, 0, 1);
    // Lane i of word k carries 3k+i+1: A sees 01,04,07,0A and so on.
    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 0; k < ARR_LEN; k++) begin
        n_checks++;
        if (rx_log[ch].size() <= k) begin
          n_fail++; $display("FAIL basic_elem[%0d][%0d]: got none expected %h", ch, k, 3*k + ch + 1);
        end else if (rx_log[ch][k] !== EW'(3*k + ch + 1)) begin
          n_fail++; $display("FAIL basic_elem[%0d][%0d]: got %h expected %h", ch, k, rx_log[ch][k], 3*k + ch + 1);
        end
      end
      n_checks++;
      if (last_cnt[ch] != 1) begin
        n_fail++; $display("FAIL basic_last_cnt[%0d]: got %0d expected 1", ch, last_cnt[ch]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int guard;
    clear_stats();
    start_frame(2'd3);
    fork
      stream(ARR_LEN, 0, 100, 1'b1, cyc);
      begin
        guard = 0;
        do begin @(negedge clk); guard++; end while (!out_valid[2] && guard < 20);
        @(posedge clk); #1;
        out_ready = 4'b1011;
        repeat (5) begin
          @(negedge clk);
          n_checks += 2;
          if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready);
          end
          if (mq[2].size() == 0) begin
            n_fail++; $display("FAIL bp_lane_c: got %h expected a held element", out_data[2*EW +: EW]);
          end else if (out_data[2*EW +: EW] !== mq[2][0][EW-1:0]) begin
            n_fail++; $display("FAIL bp_lane_c: got %h expected %h", out_data[2*EW +: EW], mq[2][0][EW-1:0]);
          end
        end
        @(posedge clk); #1;
        out_ready = 4'hF;
      end
    join
    wait_idle(50);
    check_counts("bp", 4, 4, 4, 4, 1);
  endtask

  task automatic test_single();
    int cyc;
    clear_stats();
    out_ready = 4'b0001;
    start_frame(2'd0);
    stream(ARR_LEN, 0, 100, 1'b0, cyc);
    wait_idle(50);
    n_checks++;
    if (cyc != ARR_LEN) begin
      n_fail++; $display("FAIL single_throughput: got %0d cycles expected %0d", cyc, ARR_LEN);
    end
    check_counts("single", 4, 0, 0, 0, 1);
    out_ready = 4'hF;
  endtask

  task automatic test_abort();
    int cyc;
    clear_stats();
    start_frame(2'd3);
    stream(2, 0, 100, 1'b1, cyc);
    abort = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = word_of(2);
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0; in_valid = 1'b0;
    n_checks += 4;
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (out_valid !== 4'h0) begin n_fail++; $display("FAIL abort_out_valid: got %b expected 0000", out_valid); end
    if (out_last !== 4'h0)  begin n_fail++; $display("FAIL abort_out_last: got %b expected 0000", out_last); end
    if (done_cnt != 0)      begin n_fail++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
    repeat (2) @(posedge clk);
    #1;
    clear_stats();
    start_frame(2'd3);
    stream(ARR_LEN, 10, 100, 1'b1, cyc);
    wait_idle(50);
    check_counts("post_abort", 4, 4, 4, 4, 1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (last_cnt[i] != 1) begin
        n_fail++; $display("FAIL post_abort_last[%0d]: got %0d expected 1", i, last_cnt[i]);
      end
    end
  endtask

  task automatic test_start_in_run();
    int cyc;
    clear_stats();
    start_frame(2'd1);
    stream(2, 0, 100, 1'b1, cyc);
    start = 1'b1; cfg_num_arr = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    stream(2, 2, 100, 1'b1, cyc);
    wait_idle(50);
    check_counts("start_in_run", 4, 4, 0, 0, 1);
    n_checks++;
    if (last_cnt[1] != 1) begin
      n_fail++; $display("FAIL start_in_run_last: got %0d expected 1", last_cnt[1]);
    end
  endtask

  task automatic test_random();
    int cyc;
    rand_rdy = 1'b1;
    for (int f = 0; f < 8; f++) begin
      clear_stats();
      start_frame(2'($urandom_range(3)));
      stream(ARR_LEN, 0, $urandom_range(40, 100), 1'b0, cyc);
      wait_idle(300);
      n_checks += 2;
      if (done_cnt != 1) begin
        n_fail++; $display("FAIL rand_done[%0d]: got %0d expected 1", f, done_cnt);
      end
      if (rx_cnt[0] != ARR_LEN) begin
        n_fail++; $display("FAIL rand_rx_a[%0d]: got %0d expected %0d", f, rx_cnt[0], ARR_LEN);
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 4'hF;
  endtask

  task automatic test_reset_drain();
    int cyc;
    clear_stats();
    start_frame(2'd3);
    stream(ARR_LEN, 0, 100, 1'b1, cyc);
    out_ready = 4'h0;
    @(posedge clk); #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    n_checks += 6;
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_drain_busy: got %b expected 0", busy); end
    if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_drain_done: got %b expected 0", done); end
    if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_drain_in_ready: got %b expected 0", in_ready); end
    if (out_valid !== 4'h0) begin n_fail++; $display("FAIL rst_drain_out_valid: got %b expected 0000", out_valid); end
    if (out_last !== 4'h0)  begin n_fail++; $display("FAIL rst_drain_out_last: got %b expected 0000", out_last); end
    if (out_data !== '0)    begin n_fail++; $display("FAIL rst_drain_out_data: got %h expected 0", out_data); end
    @(posedge clk); #2;
    rst_n = 1'b1; out_ready = 4'hF;
    model_clear(); clear_stats();
    mon_en = 1'b1;
    in_valid = 1'b1; in_data = word_of(5);
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    start_frame(2'd2);
    stream(ARR_LEN, 20, 100, 1'b1, cyc);
    wait_idle(50);
    check_counts("post_reset", 4, 4, 4, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    model_clear();
    test_reset();
    test_basic();
    test_backpressure();
    test_single();
    test_abort();
    test_start_in_run();
    test_random();
    test_reset_drain();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
